fp_int_convert: RTL and testbench
=================================

# fp_int_convert

- Multi-cycle single-precision conversion unit for the FP coprocessor; sits beside the combinational FP add/sub unit.
- Implements cvt.s.w (signed int32 → float32) and cvt.w.s (float32 → signed int32, truncating toward zero).
- Normalizes or denormalizes one bit per cycle; the datapath is a single 32-bit shifter register.
- The pipeline control drives it with a start/busy/done handshake.

## Interface
Parameters: none.

Clocking and reset (already decided): one clock; reset is asynchronous and active-low.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- dir  input  1  0 = int→fp, 1 = fp→int; sampled with start
- operand  input  32  source value; sampled with start
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; result and flags valid
- result  output  32  converted value; held until the next done
- inexact  output  1  nonzero bits discarded
- invalid  output  1  fp→int source is NaN/Inf or out of int32 range

## Operation
- States: IDLE, NORM, DONE. start is accepted in IDLE or DONE (busy=0) and moves the FSM to NORM. In NORM, busy=1 and start is ignored.
- Capture on accept: sign, 33-bit magnitude register mag, exponent/count register, sticky=0, special flag.
- int→fp capture:
  - sign=operand[31]; mag=|operand|, so 0x80000000 gives mag=2^31.
  - exp=158.
  - operand==0 → special, result 0x00000000.
- int→fp in NORM, each edge:
  - If mag[31]=1: result={sign, exp[7:0], mag[30:8]}, inexact=|mag[7:0]; go to DONE.
  - Otherwise: mag<<=1, exp-=1.
  - Exponent range 127..158, so overflow is impossible.
- fp→int capture, with e=operand[30:23]:
  - e==0 is treated as zero; denormals flush.
  - e==255 → invalid. NaN → 0x7FFFFFFF; ±Inf → 0x7FFFFFFF or 0x80000000 by sign.
  - e≥158, except operand==0xCF000000 → invalid, saturate by sign.
  - operand==0xCF000000 → 0x80000000, no flags.
  - e<127 → result 0, inexact=|operand[30:0].
  - Otherwise: mag={1, operand[22:0], 8'b0}, count=158−e (range 1..31).
- fp→int in NORM, each edge:
  - If count==0: result=sign ? −mag[31:0] : mag[31:0], inexact=sticky; go to DONE.
  - Otherwise: sticky|=mag[0], mag>>=1, count-=1.
- Special cases resolve at the first NORM edge.
- invalid and inexact are mutually exclusive. Both update only at the DONE transition.
- DONE lasts one cycle: done=1, then IDLE, or NORM if a new start is accepted in that cycle.

## Timing
- Reset values: busy=0, done=0, result=0x00000000, inexact=0, invalid=0; state IDLE. Reset applies immediately at any point, including mid-conversion; the partial result is discarded and no done is produced.
- Latency, counted in edges from the edge that accepts start to the edge that asserts done:
  - int→fp: lz+1, where lz is the count of leading zeros of mag (range 0..31). Operand 1 takes 32 edges; 0x80000000 takes 1.
  - fp→int: (158−e)+1.
  - Special cases: 1.
- busy rises on the accepting edge and falls on the edge that asserts done.
- Back-to-back: a start in the DONE cycle is accepted, so one idle cycle between conversions is not required.
- result, inexact and invalid are stable from the done edge until the next done edge.

## Test plan
- int→fp 0x00000001 → 0x3F800000, done exactly 32 edges after the start edge, inexact=0. Then −1 (0xFFFFFFFF) → 0xBF800000.
- int→fp 0x80000000 → 0xCF000000 at latency 1. 0x7FFFFFFF → 0x4EFFFFFF, inexact=1. 0 → 0x00000000 at latency 1.
- fp→int 0xC0490FDB (−3.14159) → 0xFFFFFFFD, inexact=1, latency 31. 0x3F000000 (0.5) → 0, inexact=1, latency 1.
- fp→int 0x4F000000 → 0x7FFFFFFF, invalid=1. 0xCF000000 → 0x80000000, invalid=0. 0x7FC00000 → 0x7FFFFFFF, invalid=1. 0xFF800000 → 0x80000000, invalid=1.
- Pulse start with operand 5 during NORM of a long conversion → the second start is ignored and exactly one done fires with the first result. Start in the DONE cycle → the second conversion runs with no gap.
- Assert rst_n=0 mid-NORM → all outputs read zero on the same cycle, no done pulse. After release, a fresh conversion completes correctly.

Source files
------------

// File: rtl/fp_int_convert_if.sv
// Handshake and data bundle between the FP pipeline control and fp_int_convert.
interface fp_int_convert_if;
  logic        start;
  logic        dir;
  logic [31:0] operand;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        inexact;
  logic        invalid;

  modport master (
    output start, dir, operand,
    input  busy, done, result, inexact, invalid
  );

  modport slave (
    input  start, dir, operand,
    output busy, done, result, inexact, invalid
  );
endinterface

// File: rtl/fp_int_convert.sv
// Serial int32 <-> float32 converter: one shift of a single magnitude register per cycle,
// truncating toward zero in both directions.
module fp_int_convert (
  input  logic            clk,
  input  logic            rst_n,
  fp_int_convert_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_NORM, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_dir, r_sign, r_special, r_sticky, r_sp_inx, r_sp_inv;
  logic [32:0] r_mag;
  logic [7:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_inexact, r_invalid;

  logic        w_accept, w_fin;
  logic [7:0]  w_e;
  logic [22:0] w_f;
  logic [31:0] w_abs;
  logic [32:0] w_cap_mag;
  logic [7:0]  w_cap_cnt;
  logic        w_cap_special, w_cap_inx, w_cap_inv;

  assign w_accept = bus.start && (r_state != S_NORM);
  assign w_fin    = (r_state == S_NORM) &&
                    (r_special || (!r_dir && r_mag[31]) || (r_dir && (r_cnt == 8'd0)));
  assign w_e      = bus.operand[30:23];
  assign w_f      = bus.operand[22:0];
  // 32-bit negate yields the right unsigned magnitude even for 0x80000000
  assign w_abs    = bus.operand[31] ? (~bus.operand + 32'd1) : bus.operand;

  // Special results are parked in the magnitude register and emitted on the first NORM edge
  always_comb begin
    w_cap_mag     = '0;
    w_cap_cnt     = '0;
    w_cap_special = 1'b0;
    w_cap_inx     = 1'b0;
    w_cap_inv     = 1'b0;
    if (!bus.dir) begin
      w_cap_mag     = {1'b0, w_abs};
      w_cap_cnt     = 8'd158;
      w_cap_special = (bus.operand == 32'd0);
    end else if (w_e == 8'hFF) begin
      w_cap_special   = 1'b1;
      w_cap_inv       = 1'b1;
      w_cap_mag[31:0] = ((w_f != 23'd0) || !bus.operand[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else if (bus.operand == 32'hCF00_0000) begin
      w_cap_special   = 1'b1;
      w_cap_mag[31:0] = 32'h8000_0000;
    end else if (w_e >= 8'd158) begin
      w_cap_special   = 1'b1;
      w_cap_inv       = 1'b1;
      w_cap_mag[31:0] = bus.operand[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (w_e < 8'd127) begin
      // e==0 flushes to an exact zero; any other small exponent is a nonzero fraction
      w_cap_special = 1'b1;
      w_cap_inx     = (w_e != 8'd0);
    end else begin
      w_cap_mag = {1'b0, 1'b1, w_f, 8'd0};
      w_cap_cnt = 8'd158 - w_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_NORM;
      S_NORM:  if (w_fin)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_accept ? S_NORM : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir     <= 1'b0;
      r_sign    <= 1'b0;
      r_special <= 1'b0;
      r_sticky  <= 1'b0;
      r_sp_inx  <= 1'b0;
      r_sp_inv  <= 1'b0;
      r_mag     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_inexact <= 1'b0;
      r_invalid <= 1'b0;
    end else if (w_accept) begin
      r_dir     <= bus.dir;
      r_sign    <= bus.operand[31];
      r_special <= w_cap_special;
      r_sticky  <= 1'b0;
      r_sp_inx  <= w_cap_inx;
      r_sp_inv  <= w_cap_inv;
      r_mag     <= w_cap_mag;
      r_cnt     <= w_cap_cnt;
    end else if (r_state == S_NORM) begin
      if (r_special) begin
        r_result  <= r_mag[31:0];
        r_inexact <= r_sp_inx;
        r_invalid <= r_sp_inv;
      end else if (!r_dir) begin
        // r_cnt doubles as the biased exponent while normalizing left
        if (r_mag[31]) begin
          r_result  <= {r_sign, r_cnt, r_mag[30:8]};
          r_inexact <= |r_mag[7:0];
          r_invalid <= 1'b0;
        end else begin
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt - 8'd1;
        end
      end else begin
        if (r_cnt == 8'd0) begin
          r_result  <= r_sign ? -r_mag[31:0] : r_mag[31:0];
          r_inexact <= r_sticky;
          r_invalid <= 1'b0;
        end else begin
          r_sticky <= r_sticky | r_mag[0];
          r_mag    <= r_mag >> 1;
          r_cnt    <= r_cnt - 8'd1;
        end
      end
    end
  end

  assign bus.busy    = (r_state == S_NORM);
  assign bus.done    = (r_state == S_DONE);
  assign bus.result  = r_result;
  assign bus.inexact = r_inexact;
  assign bus.invalid = r_invalid;
endmodule

// File: tb/tb_fp_int_convert.sv
// Randomized bench for fp_int_convert: an arithmetic reference model predicts each
// conversion, and a single negedge monitor checks busy/done/result/flags/latency.
module tb_fp_int_convert;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_int_convert_if bus();
  fp_int_convert dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        dir;
    logic [31:0] op;
    logic [31:0] res;
    logic        inx;
    logic        inv;
    int          lat;
    int          acc;
    logic        pin;
    logic [31:0] p_res;
    logic        p_inx;
    logic        p_inv;
    int          p_lat;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_busy;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic d, input logic [31:0] op);
    exp_t        m;
    longint      v, mg, mant, sig;
    int          p, sh;
    logic [7:0]  e;
    logic [22:0] f;
    m.dir = d; m.op = op; m.res = '0; m.inx = 1'b0; m.inv = 1'b0; m.lat = 1;
    m.acc = 0; m.pin = 1'b0; m.p_res = '0; m.p_inx = 1'b0; m.p_inv = 1'b0; m.p_lat = 0;
    if (!d) begin
      if (op != 32'd0) begin
        v  = longint'($signed(op));
        mg = (v < 0) ? -v : v;
        p  = 0;
        for (int i = 0; i < 32; i++) if (mg[i]) p = i;
        sh   = p - 23;
        mant = (sh >= 0) ? (mg >> sh) : (mg << -sh);
        m.res = {op[31], 8'(127 + p), mant[22:0]};
        m.inx = (sh > 0) && ((mg & ((64'sd1 << sh) - 1)) != 0);
        m.lat = 32 - p;
      end
    end else begin
      e = op[30:23];
      f = op[22:0];
      if (e == 8'd255) begin
        m.inv = 1'b1;
        m.res = ((f != 0) || !op[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end else if (op == 32'hCF00_0000) begin
        m.res = 32'h8000_0000;
      end else if (e >= 8'd158) begin
        m.inv = 1'b1;
        m.res = op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else if (e == 8'd0) begin
        m.res = 32'd0;
      end else if (e < 8'd127) begin
        m.inx = 1'b1;
      end else begin
        sig = longint'({1'b1, f});
        sh  = int'(e) - 150;
        if (sh >= 0) v = sig << sh;
        else begin
          v     = sig >> (-sh);
          m.inx = (sig & ((64'sd1 << -sh) - 1)) != 0;
        end
        m.res = op[31] ? 32'(-v) : 32'(v);
        m.lat = 159 - int'(e);
      end
    end
    return m;
  endfunction

  // Sole checker: every counted comparison lives here
  always @(negedge clk) begin
    if (!rst_n) begin
      n_tests++;
      if (bus.busy || bus.done || bus.result != 32'd0 || bus.inexact || bus.invalid) begin
        n_fail++;
        $display("FAIL reset_outputs: got busy=%b done=%b result=%h inx=%b inv=%b, want all zero",
                 bus.busy, bus.done, bus.result, bus.inexact, bus.invalid);
      end
    end else begin
      exp_busy = (q.size() > 0) && !bus.done;
      n_tests++;
      if (bus.busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy @cyc %0d: got %b want %b", cyc, bus.busy, exp_busy);
      end
      if (bus.done) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_done @cyc %0d: got done=1 want no done", cyc);
        end else begin
          m_e = q.pop_front();
          n_tests += 3;
          if (bus.result !== m_e.res) begin
            n_fail++;
            $display("FAIL result dir=%0d op=%h: got %h want %h", m_e.dir, m_e.op, bus.result, m_e.res);
          end
          if ({bus.inexact, bus.invalid} !== {m_e.inx, m_e.inv}) begin
            n_fail++;
            $display("FAIL flags dir=%0d op=%h: got inx=%b inv=%b want inx=%b inv=%b",
                     m_e.dir, m_e.op, bus.inexact, bus.invalid, m_e.inx, m_e.inv);
          end
          if (cyc - m_e.acc != m_e.lat) begin
            n_fail++;
            $display("FAIL latency dir=%0d op=%h: got %0d want %0d", m_e.dir, m_e.op, cyc - m_e.acc, m_e.lat);
          end
          if (m_e.pin) begin
            n_tests++;
            if ({m_e.res, m_e.inx, m_e.inv} !== {m_e.p_res, m_e.p_inx, m_e.p_inv} || m_e.lat != m_e.p_lat) begin
              n_fail++;
              $display("FAIL model_pin op=%h: got %h/%b/%b/%0d want %h/%b/%b/%0d", m_e.op,
                       m_e.res, m_e.inx, m_e.inv, m_e.lat, m_e.p_res, m_e.p_inx, m_e.p_inv, m_e.p_lat);
            end
          end
        end
      end else if (q.size() > 0 && (cyc - q[0].acc) > 40) begin
        m_e = q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL timeout op=%h: got no done after %0d cycles want done", m_e.op, cyc - m_e.acc);
      end
    end
  end

  task automatic issue(input logic d, input logic [31:0] op, input logic pin,
                       input logic [31:0] pr, input logic pinx, input logic pinv, input int plat);
    exp_t e;
    bus.start = 1'b1; bus.dir = d; bus.operand = op;
    @(posedge clk); #1;
    e = model(d, op);
    e.acc = cyc; e.pin = pin; e.p_res = pr; e.p_inx = pinx; e.p_inv = pinv; e.p_lat = plat;
    q.push_back(e);
    @(negedge clk); #1;
    bus.start = 1'b0; bus.dir = 1'($urandom); bus.operand = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 42; i++) begin
      if (bus.done) return;
      @(negedge clk); #1;
    end
  endtask

  task automatic run(input logic d, input logic [31:0] op, input logic [31:0] pr,
                     input logic pinx, input logic pinv, input int plat);
    issue(d, op, 1'b1, pr, pinx, pinv, plat);
    wait_done();
  endtask

  initial begin
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [31:0] op;
    bus.start = 1'b0; bus.dir = 1'b0; bus.operand = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // Directed, back-to-back: each start lands in the previous DONE cycle
    run(1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0, 32);
    run(1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0, 32);
    run(1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 1'b0, 1);
    run(1'b0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b1, 1'b0, 2);
    run(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
    run(1'b1, 32'hC049_0FDB, 32'hFFFF_FFFD, 1'b1, 1'b0, 31);
    run(1'b1, 32'h3F00_0000, 32'h0000_0000, 1'b1, 1'b0, 1);
    run(1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    run(1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
    run(1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    run(1'b1, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b1, 1);
    run(1'b1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 32);
    repeat (2) @(negedge clk);
    #1;

    // A start pulsed mid-conversion must be ignored
    issue(1'b0, 32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32);
    repeat (5) @(negedge clk);
    #1 bus.start = 1'b1; bus.dir = 1'b0; bus.operand = 32'd5;
    @(negedge clk);
    #1 bus.start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    #1;

    // Reset mid-NORM discards the conversion
    issue(1'b0, 32'h0000_0001, 1'b0, '0, 1'b0, 1'b0, 0);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    run(1'b0, 32'h0000_0003, 32'h4040_0000, 1'b0, 1'b0, 31);

    // Randomized conversions with 0..2 idle cycles between them
    for (int n = 0; n < 160; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        op = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) op = -op;
        issue(1'b0, op, 1'b0, '0, 1'b0, 1'b0, 0);
      end else begin
        s = 1'($urandom);
        e = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(120, 160));
        f = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
        issue(1'b1, {s, e, f}, 1'b0, '0, 1'b0, 1'b0, 0);
      end
      wait_done();
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
      end
    end

    repeat (45) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
